// File: rtl/p2_mem_write.sv
// rtl/p2_mem_write.sv - 2x2 signed max-pool engine and write addresser for the P2 memory
//
// Consumes the conv2 pixel stream in raster order (IN_DIM x IN_DIM per channel,
// CHANNELS channels back to back). Each 2x2 window is reduced to its signed
// maximum and written to the 4x4-per-channel P2 memory at addr0 within channel count.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; clears all state
//   enable   in   block enable; while low, beats are ignored and state holds
//   in_valid in   one pixel presented this cycle
//   in_data  in   signed pixel, DATA_W bits
//   addr0    out  word address within the channel, (r/2)*4 + c/2
//   count    out  channel index of the data being written
//   we       out  one-cycle write strobe per pooled word
//   wdata    out  pooled signed maximum
//   done     out  sticky; set with the final word of the last channel
module p2_mem_write #(
  parameter int DATA_W   = 16,
  parameter int IN_DIM   = 8,
  parameter int CHANNELS = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [3:0]               addr0,
  output logic [3:0]               count,
  output logic                     we,
  output logic signed [DATA_W-1:0] wdata,
  output logic                     done
);

  localparam logic [2:0] LAST_POS = 3'(IN_DIM - 1);
  localparam logic [3:0] LAST_CH  = 4'(CHANNELS - 1);

  logic [2:0]               r_q, r_d;
  logic [2:0]               c_q, c_d;
  logic [3:0]               ch_q, ch_d;
  logic signed [DATA_W-1:0] pair_q, pair_d;
  logic signed [DATA_W-1:0] part_q [4];
  logic signed [DATA_W-1:0] part_d [4];
  logic [3:0]               addr0_q, addr0_d;
  logic [3:0]               count_q, count_d;
  logic                     we_q, we_d;
  logic signed [DATA_W-1:0] wdata_q, wdata_d;
  logic                     done_q, done_d;

  logic                     accept;
  logic [1:0]               col_pair;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] part_max;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign accept   = enable && in_valid && !done_q;
  assign col_pair = c_q[2:1];
  assign pair_max = smax(pair_q, in_data);
  assign part_max = smax(part_q[col_pair], in_data);

  always_comb begin
    r_d     = r_q;
    c_d     = c_q;
    ch_d    = ch_q;
    pair_d  = pair_q;
    part_d  = part_q;
    addr0_d = addr0_q;
    count_d = count_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    we_d    = 1'b0;

    if (accept) begin
      if (c_q == LAST_POS) begin
        c_d = 3'd0;
        r_d = (r_q == LAST_POS) ? 3'd0 : r_q + 3'd1;
      end else begin
        c_d = c_q + 3'd1;
      end

      // Even rows fold each horizontal pair into the partial buffer; odd rows
      // merge the buffered top half and emit on the bottom-right pixel.
      case ({r_q[0], c_q[0]})
        2'b00: pair_d = in_data;
        2'b01: part_d[col_pair] = pair_max;
        2'b10: pair_d = part_max;
        2'b11: begin
          wdata_d = pair_max;
          addr0_d = {r_q[2:1], col_pair};
          count_d = ch_q;
          we_d    = 1'b1;
          if (r_q == LAST_POS && c_q == LAST_POS) begin
            // Channel index stops at the last channel; done freezes the block.
            if (ch_q == LAST_CH) begin
              done_d = 1'b1;
            end else begin
              ch_d = ch_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      c_q     <= '0;
      ch_q    <= '0;
      pair_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        part_q[i] <= '0;
      end
      addr0_q <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      c_q     <= c_d;
      ch_q    <= ch_d;
      pair_q  <= pair_d;
      for (int i = 0; i < 4; i++) begin
        part_q[i] <= part_d[i];
      end
      addr0_q <= addr0_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign addr0 = addr0_q;
  assign count = count_q;
  assign we    = we_q;
  assign wdata = wdata_q;
  assign done  = done_q;

endmodule

// File: doc/p2_mem_write.md
Name: p2_mem_write

Overview:
- Write-side addresser and 2x2 max-pool engine for the pooling-layer-2 output memory.
- Consumes the conv2 output stream in raster order: IN_DIM x IN_DIM pixels per channel, CHANNELS channels in sequence.
- Reduces each 2x2 window to its signed maximum.
- Writes each result into the 4x4-per-channel P2 memory, using the same addr0/count addressing that the P2 read side walks.
- Asserts done when the last channel's last word is written.

Parameters:
- DATA_W, 16, width of signed pixel and pooled data.
- IN_DIM, 8, input feature-map side; fixed so that OUT_DIM = IN_DIM/2 = 4 and 16 words per channel.
- CHANNELS, 12, channels per image; the final channel index is CHANNELS-1 = 11.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  block enable; while low, beats are ignored and all state holds.
- in_valid  input  1  one conv2 pixel presented this cycle.
- in_data  input  DATA_W  signed pixel, raster order (row-major within a channel, channels consecutive).
- addr0  output  4  word address within the channel, = (r/2)*4 + c/2.
- count  output  4  channel index, 0..11.
- we  output  1  write strobe, one cycle per pooled word.
- wdata  output  DATA_W  pooled maximum.
- done  output  1  all CHANNELS*16 words written; sticky.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: addr0=0, count=0, we=0, wdata=0, done=0. Internal counters (row r, col c) = 0. Partial buffer (4 x DATA_W) and pair register are cleared. reset asserted mid-image aborts the image with no further writes; the next beat after release is treated as pixel (0,0) of channel 0.
- Accepted beat: a beat is accepted when enable && in_valid && !done. No back-pressure: every accepted beat is consumed. Non-accepted cycles change no state except that we drops to 0.
- Position tracking: c increments per accepted beat and wraps 7->0, incrementing r. r wraps 7->0, which ends the channel.
- Even row r, even c: pair <= in_data.
- Even row r, odd c: buf[c/2] <= max(pair, in_data).
- Odd row r, even c: pair <= max(buf[c/2], in_data).
- Odd row r, odd c: on the next edge, wdata <= max(pair, in_data), addr0 <= (r/2)*4 + c/2, count <= current channel, we <= 1.
- Latency: we rises exactly 1 cycle after the 4th pixel of a window is accepted. we is high for exactly 1 cycle per write, and back-to-back writes are impossible (minimum spacing is 2 accepted beats).
- Output hold: addr0, count and wdata hold their last values while we=0.
- Comparison: all comparisons are signed two's-complement, DATA_W bits, with no truncation. On ties, the value written is identical either way.
- Channel counting: the channel counter increments after the write to addr0=15. count presented with a write is always the channel that produced that data.
- Completion: done <= 1 on the same edge that presents the write with count=11, addr0=15. From then on, all beats are ignored and done stays 1 until reset. Addresses never wrap past channel 11.
- enable: enable low mid-window pauses the window; the partial buffer and pair are preserved. When enable returns high, the window resumes at the same (r, c).

Test Plan:
- Ramp, 1 channel: feed channel 0 with in_data = r*8+c, continuous valid -> 16 writes with wdata = (2i+1)*8+2j+1 at addr0 = i*4+j. addr0=0 gives 9, addr0=15 gives 63, count=0. Each we occurs 1 cycle after the beat at (odd r, odd c).
- Signed max: all pixels -5 except one -3 per window, placed at a different corner of each window -> every wdata = -3 (0xFFFD). Second pass with -32768 and 32767 -> 32767.
- Gapped valid and enable: random in_valid gaps plus enable dropped for 3 cycles mid-window, repeating the ramp -> identical write sequence to the continuous ramp case. Beats offered while enable=0 are not counted.
- Full image: 12 channels x 64 beats, channel k pixel = k*100 + r*8 + c -> 192 writes. Last write has count=11, addr0=15, wdata=1163, with done rising on the same edge. Extra beats afterwards produce no we; done stays 1.
- Reset mid-operation: assert reset after 100 beats (channel 1, r=4, c=4) -> all outputs 0 immediately, asynchronously. A fresh ramp then yields channel-0 writes starting at addr0=0, count=0.
